// File: rtl/tff_bank_arbiter_if.sv
// Requester-side bus of the T flip-flop bank arbiter: requests, toggle masks, grant/ack and bank contents.
// The lock vector exists only when TFF_BANK_LOCK_EN is defined.
interface tff_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] tmask;
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic                  busy;
  logic [WIDTH-1:0]      Q;
`ifdef TFF_BANK_LOCK_EN
  logic [NREQ-1:0]       lock;

  modport master (output req, tmask, lock, input gnt, ack, busy, Q);
  modport slave  (input req, tmask, lock, output gnt, ack, busy, Q);
`else
  modport master (output req, tmask, input gnt, ack, busy, Q);
  modport slave  (input req, tmask, output gnt, ack, busy, Q);
`endif
endinterface

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter in front of a WIDTH-bit T flip-flop bank; one granted toggle mask per transaction.
// Optional TFF_BANK_LOCK_EN lets a granted requester chain back-to-back transactions without re-arbitration.
module tff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic reset,
  tff_bank_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t           state_reg;
  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    winner_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] q_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic             ack_reg;

  logic [IW-1:0]    win_next;
  logic             win_found;
  int               idx;
  logic             relock;
  logic [WIDTH-1:0] slice [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = bus.tmask[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First requesting index after the pointer, wrapping, so the last winner ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_next  = ptr_reg;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_next  = IW'(idx);
      end
    end
  end

`ifdef TFF_BANK_LOCK_EN
  assign relock = bus.lock[winner_reg] && bus.req[winner_reg];
`else
  assign relock = 1'b0;
`endif

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      ptr_reg    <= IW'(NREQ - 1);
      winner_reg <= '0;
      mask_reg   <= '0;
      q_reg      <= '0;
      gnt_reg    <= '0;
      ack_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            winner_reg <= win_next;
            gnt_reg    <= NREQ'(1) << win_next;
            mask_reg   <= slice[win_next];
            state_reg  <= GRANT;
          end
        end
        GRANT: begin
          q_reg     <= q_reg ^ mask_reg;
          ack_reg   <= 1'b1;
          state_reg <= ACK;
        end
        ACK: begin
          ack_reg <= 1'b0;
          // A locked holder keeps gnt and the pointer; only its fresh mask is taken.
          if (relock) begin
            mask_reg  <= slice[winner_reg];
            state_reg <= GRANT;
          end else begin
            gnt_reg   <= '0;
            ptr_reg   <= winner_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt  = gnt_reg;
  assign bus.ack  = ack_reg;
  assign bus.busy = (state_reg != IDLE);
  assign bus.Q    = q_reg;
endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Randomised scoreboard bench for tff_bank_arbiter: a round-robin reference model predicts each acked transaction.
// Covers reset, ordering, latency, zero mask, early drop, mid-transaction reset and (with TFF_BANK_LOCK_EN) locking.
module tb_tff_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic Clk   = 1'b0;
  logic reset = 1'b1;
  always #5 Clk = ~Clk;

  tff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

  tff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] q;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               errors = 0;
  int               checks = 0;
  bit               mon_en = 1'b0;
  int               m_ptr  = NREQ - 1;
  logic [WIDTH-1:0] m_q    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule: scan upward from the last winner, wrapping modulo NREQ.
  function automatic int rr_pick(input logic [NREQ-1:0] set, input int ptr);
    for (int k = 1; k <= NREQ; k++)
      if (set[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Monitor: every ack must match the next predicted transaction.
  initial begin
    forever begin
      @(negedge Clk);
      if (mon_en && !reset) begin
        chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
        if (bus.ack) begin
          if (sb.size() == 0) begin
            chk("ack_without_expected_txn", 32'(sb.size()), 32'd1);
          end else begin
            mon_e = sb.pop_front();
            chk("grant_id", 32'(bus.gnt), 32'd1 << mon_e.idx);
            chk("q_after_ack", 32'(bus.Q), 32'(mon_e.q));
            chk("busy_in_ack", 32'(bus.busy), 32'd1);
            $display("txn: requester %0d Q=%02h gnt=%b", mon_e.idx, bus.Q, bus.gnt);
          end
        end
      end
    end
  end

  // Raise a set of requests, predict the service order, and act as the requesters until all are served.
  task automatic run_batch(input logic [NREQ-1:0] set, input logic [NREQ*WIDTH-1:0] masks,
                           input int early, output int cycles);
    logic [NREQ-1:0] pend;
    int              w;
    bit              done;
    pend = set;
    while (pend != 0) begin
      w    = rr_pick(pend, m_ptr);
      m_q  = m_q ^ masks[w*WIDTH +: WIDTH];
      sb.push_back('{w, m_q});
      m_ptr   = w;
      pend[w] = 1'b0;
    end
    @(negedge Clk);
    bus.tmask = masks;
    bus.req   = set;
    cycles    = 0;
    done      = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge Clk);
      cycles++;
      @(negedge Clk);
      if (cycles == 1) chk("gnt_one_edge_after_req", 32'(bus.gnt != 0), 32'd1);
      if (!bus.busy && bus.req == 0 && sb.size() == 0) begin
        done = 1'b1;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (bus.gnt[i]) begin
            if (bus.ack) bus.req[i] = 1'b0;
            else if (early == 2 || (early == 1 && $urandom_range(1, 0) == 1)) bus.req[i] = 1'b0;
            bus.tmask[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          end
        end
      end
    end
    chk("batch_completes", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int                    cyc;
    logic [NREQ-1:0]       set;
    logic [NREQ*WIDTH-1:0] masks;
    bus.req   = '0;
    bus.tmask = '0;
`ifdef TFF_BANK_LOCK_EN
    bus.lock  = '0;
`endif
    // Reset and idle
    @(negedge Clk);
    chk("rst_q", 32'(bus.Q), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge Clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      chk("idle_q", 32'(bus.Q), 32'd0);
      chk("idle_gnt", 32'(bus.gnt), 32'd0);
      chk("idle_ack", 32'(bus.ack), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end
    mon_en = 1'b1;

    // Round-robin order 0,1,2,3 from the reset pointer, 12 cycles in total
    run_batch(4'b1111, 32'h08040201, 0, cyc);
    chk("rr_total_cycles", 32'(cyc), 32'd12);

    // Single requester twice with the same mask
    run_batch(4'b0001, 32'h0000000F, 0, cyc);
    run_batch(4'b0001, 32'h0000000F, 0, cyc);

    // Zero mask, then early drop during GRANT
    run_batch(4'b1000, 32'h00000000, 0, cyc);
    run_batch(4'b0100, 32'h00800000, 2, cyc);

    // Randomised batches
    for (int t = 0; t < 40; t++) begin
      set = NREQ'($urandom_range(15, 1));
      for (int i = 0; i < NREQ; i++) masks[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      run_batch(set, masks, 1, cyc);
    end

    // Reset during GRANT aborts immediately; the captured mask is discarded
    run_batch(4'b0001, 32'h00000055, 0, cyc);
    @(negedge Clk);
    bus.tmask = 32'hFFFFFFFF;
    bus.req   = 4'b0001;
    @(posedge Clk);
    @(negedge Clk);
    chk("pre_reset_in_grant", 32'(bus.gnt), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_q", 32'(bus.Q), 32'd0);
    chk("async_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("async_rst_ack", 32'(bus.ack), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    bus.req = '0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_held_q", 32'(bus.Q), 32'd0);
    reset = 1'b0;
    m_q   = '0;
    m_ptr = NREQ - 1;
    run_batch(4'b0110, 32'h00A05000, 0, cyc);

`ifdef TFF_BANK_LOCK_EN
    // Locked requester 1 chains three transactions while requester 2 waits
    begin
      int  n;
      bit  seen, r2_up, done;
      n = 0; seen = 1'b0; r2_up = 1'b0; done = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_q = m_q ^ 8'hFF;
        sb.push_back('{1, m_q});
      end
      m_q = m_q ^ 8'h3C;
      sb.push_back('{2, m_q});
      m_ptr = 2;
      @(negedge Clk);
      bus.tmask = 32'h003CFF00;
      bus.req   = 4'b0010;
      bus.lock  = 4'b0010;
      for (int c = 0; c < 100 && !done; c++) begin
        @(posedge Clk);
        @(negedge Clk);
        if (bus.gnt[1]) seen = 1'b1;
        if (seen && n < 3) chk("lock_gnt1_held", 32'(bus.gnt[1]), 32'd1);
        if (bus.ack && bus.gnt[1]) begin
          n++;
          if (n == 3) begin
            bus.req[1]  = 1'b0;
            bus.lock[1] = 1'b0;
          end
        end else if (bus.ack && bus.gnt[2]) begin
          bus.req[2] = 1'b0;
        end
        if (seen && !r2_up) begin
          bus.req[2] = 1'b1;
          r2_up      = 1'b1;
        end
        if (r2_up && !bus.busy && bus.req == 0 && sb.size() == 0) done = 1'b1;
      end
      chk("lock_sequence_completes", 32'(done), 32'd1);
      chk("lock_txn_count", 32'(n), 32'd3);
    end
`endif

    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tff_bank_arbiter.md
Name: tff_bank_arbiter

Overview:
- Shared register bank of WIDTH T flip-flops, with a round-robin arbiter in front of it.
- Any of NREQ requesters may ask to toggle a subset of the bank's bits.
- One transaction is granted at a time; the granted requester's toggle mask is applied (Q <= Q ^ mask) and completion is acknowledged.
- Sits between the lab's toggle flip-flop datapath and multiple control sources that would otherwise contend for it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of T flip-flops in the bank.

Ports:
- Clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; held high until own ack.
- tmask  input  NREQ*WIDTH  toggle masks; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, registered.
- ack  output  1  completion pulse for the granted requester, registered.
- busy  output  1  high whenever state is not IDLE.
- Q  output  WIDTH  T flip-flop bank contents.

Behaviour:
- Clocking and reset: one clock domain, Clk. reset is asynchronous and active-high.
- While reset is high:
  - Q=0, gnt=0, ack=0, busy=0.
  - state=IDLE.
  - RR pointer = NREQ-1, so requester 0 has highest priority after reset.
- Reset mid-transaction: aborts immediately. The captured mask is discarded and Q is not toggled.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If any req bit is high at an edge, select the winner, then go to GRANT.
  - Winner is the first set bit searching from pointer+1 upward, wrapping modulo NREQ.
  - On that edge: gnt <= onehot(winner); capture tmask slice of the winner into an internal mask register.
  - No req → remain in IDLE with all outputs low.
- GRANT (1 cycle):
  - gnt held, busy=1.
  - At the exit edge: Q <= Q ^ captured_mask; ack <= 1; next state ACK.
- ACK (1 cycle):
  - ack=1, gnt still high, Q already shows the new value.
  - At the exit edge: gnt <= 0, ack <= 0, pointer <= winner, next state IDLE.
- Latency and throughput:
  - Req seen at edge k → gnt high after k, Q updated and ack high after k+1, gnt/ack low after k+2.
  - Maximum throughput: one transaction per 3 cycles.
- Requester contract: drop req on the edge ending its ACK cycle.
  - A req still high in IDLE is treated as a new request, arbitrated normally behind the other requesters via the pointer.
- Req deasserted during GRANT/ACK: the transaction still completes with the captured mask. tmask changes after capture are ignored.
- Zero mask: the transaction is granted and acked normally; Q is unchanged.
- Simultaneous requests: only the RR winner is served. Others wait; no request is lost while its req stays high.
- Fairness: with all NREQ requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0,...
- Q changes only at GRANT exit edges. Never more than one gnt bit is set.

Optional Feature:
- Macro: TFF_BANK_LOCK_EN.
- With the macro defined:
  - Extra input port lock [NREQ].
  - In ACK, if the granted requester has req and lock both high, the next state is GRANT for the same requester instead of IDLE.
  - The new tmask slice is captured at the ACK exit edge. gnt stays high continuously and the pointer is not updated.
  - ack still pulses once per transaction, so back-to-back transactions take 2 cycles each.
- Without the macro: no lock port; every transaction returns to IDLE and round-robin always applies.

Test Plan (WIDTH=8, NREQ=4):
- Reset and idle: hold reset 2 cycles, then release with req=0 → Q=8'h00, gnt=4'b0000, ack=0, busy=0 for 5 cycles.
- Single requester: req[0]=1, mask0=8'h0F → gnt=0001 one edge later, ack and Q=8'h0F next edge. Repeat the transaction → Q=8'h00.
- Round-robin order: req=4'b1111, masks 01/02/04/08, each req dropped on own ack:
  - grants occur in order 0,1,2,3;
  - Q progresses 01,03,07,0F;
  - total 12 cycles.
- Reset mid-transaction: assert reset during GRANT with mask 8'hFF → Q=8'h00, gnt=0, ack=0 immediately, without waiting for a clock edge. After release with req=4'b0110 → requester 1 granted first.
- Zero mask / early drop: mask=8'h00 → ack pulses and Q is unchanged. Separately, req[2] dropped during GRANT with mask 8'h80 → transaction still completes and Q bit 7 toggles.
- TFF_BANK_LOCK_EN: req[1] and lock[1] held for 3 transactions with mask 8'hFF, req[2] pending → 3 consecutive grants to requester 1 (Q ends 8'hFF), gnt[1] never drops. Then lock[1] and req[1] are lowered → requester 2 granted next.
